mem_arbiter: RTL

//  Shares one single-ported, multi-cycle memory (stall-capable memory2c variant) between

---
 rtl/mem_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported, multi-cycle memory between the
// instruction-fetch requester and the data (load/store/dump) requester.
// Data has priority, a starvation counter guarantees fetch progress, and
// misalignment, timeout and spurious mem_done are reported on err.
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  // instruction fetch requester
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_stall,
  // data requester
  input  logic              dm_req,
  input  logic              dm_wr,
  input  logic              dm_dump,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              dm_stall,
  // memory side
  output logic              mem_en,
  output logic              mem_wr,
  output logic              mem_dump,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_stall,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_t;

  state_t            state_q;
  logic [SW-1:0]     starve_q;
  logic [TW-1:0]     tmo_q;
  logic              mem_en_q;
  logic              mem_wr_q;
  logic              mem_dump_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              if_done_q;
  logic              dm_done_q;
  logic              err_q;

  logic              if_elig;
  logic              dm_elig;
  logic              can_grant_d;
  logic              gnt_i_d;
  logic              gnt_d_d;
  logic [ADDR_W-1:0] gnt_addr_d;
  logic              misalign_d;

  // Grant selection while IDLE: data first unless fetch has waited STARVE_MAX data grants
  always_comb begin
    if_elig     = if_req & ~if_done_q;
    dm_elig     = dm_req & ~dm_done_q;
    // Grants also pause while a done pulse is out, so a requester that keeps
    // req high after its done competes with the other one on equal terms.
    can_grant_d = (state_q == IDLE) & ~mem_stall & ~mem_done & ~if_done_q & ~dm_done_q;
    gnt_d_d     = can_grant_d & dm_elig & (~if_elig | (starve_q != SW'(STARVE_MAX)));
    gnt_i_d     = can_grant_d & if_elig & ~gnt_d_d;
    gnt_addr_d  = gnt_d_d ? dm_addr : if_addr;
    misalign_d  = gnt_addr_d[0];
  end

  // Arbiter FSM with registered memory strobes, done pulses, read data and err
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      tmo_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_dump_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mem_en_q  <= 1'b0;
      if_done_q <= 1'b0;
      dm_done_q <= 1'b0;
      err_q     <= 1'b0;

      if (gnt_i_d) begin
        starve_q <= '0;
      end else if (gnt_d_d && if_elig && (starve_q != SW'(STARVE_MAX))) begin
        starve_q <= starve_q + 1'b1;
      end

      case (state_q)
        IDLE: begin
          tmo_q <= '0;
          if (mem_done) begin
            // nothing outstanding: spurious completion, data dropped
            err_q <= 1'b1;
          end else if (gnt_i_d || gnt_d_d) begin
            if (misalign_d) begin
              err_q     <= 1'b1;
              if_done_q <= gnt_i_d;
              dm_done_q <= gnt_d_d;
            end else begin
              mem_en_q   <= 1'b1;
              mem_addr_q <= gnt_addr_d;
              mem_wr_q   <= gnt_d_d & dm_wr;
              mem_dump_q <= gnt_d_d & dm_dump;
              if (gnt_d_d) begin
                mem_wdata_q <= dm_wdata;
              end
              state_q <= gnt_d_d ? BUSY_D : BUSY_I;
            end
          end
        end

        BUSY_I, BUSY_D: begin
          if (mem_done) begin
            if (state_q == BUSY_I) begin
              if_rdata_q <= mem_rdata;
              if_done_q  <= 1'b1;
            end else begin
              if (!mem_wr_q && !mem_dump_q) begin
                dm_rdata_q <= mem_rdata;
              end
              dm_done_q <= 1'b1;
            end
            state_q <= IDLE;
            tmo_q   <= '0;
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            err_q     <= 1'b1;
            if_done_q <= (state_q == BUSY_I);
            dm_done_q <= (state_q == BUSY_D);
            state_q   <= IDLE;
            tmo_q     <= '0;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_dump  = mem_dump_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign if_done   = if_done_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_done   = dm_done_q;
  assign err       = err_q;

  // Stalls are gated by rst_n so every output reads 0 while reset is held.
  assign if_stall = rst_n & if_req & ~if_done_q;
  assign dm_stall = rst_n & dm_req & ~dm_done_q;

endmodule
